// File: rtl/dvsd_param_updown_counter.sv
// Parameterised up/down counter with wrap or saturate at MAX_VAL, parallel load and crossing pulses.
// Define DVSD_CNT_STICKY_FLAG_EN to build the sticky overflow/underflow flag; otherwise ovf_sticky is 0.
module dvsd_param_updown_counter #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
    parameter int               STEP_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              updown,
    input  logic              sat_mode,
    input  logic [STEP_W-1:0] step,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              ovf_clr,
    output logic [WIDTH-1:0]  out,
    output logic              tc,
    output logic              ovf,
    output logic              unf,
    output logic              ovf_sticky
);

    // Two guard bits let up sums and down wrap sums be formed without truncation.
    localparam logic [WIDTH+1:0] MAX_X  = {2'b00, MAX_VAL};
    localparam logic [WIDTH+1:0] MAX_P1 = MAX_X + 1'b1;

    logic [WIDTH+1:0] cur_x;
    logic [WIDTH+1:0] step_x;
    logic [WIDTH+1:0] sum;
    logic [WIDTH-1:0] next_out;
    logic             next_ovf;
    logic             next_unf;

    assign cur_x  = {2'b00, out};
    assign step_x = {{(WIDTH+2-STEP_W){1'b0}}, step};
    assign sum    = cur_x + step_x;

    // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
    always_comb begin
        next_out = out;
        next_ovf = 1'b0;
        next_unf = 1'b0;
        if (load) begin
            next_out = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (en) begin
            if (updown) begin
                if (sum > MAX_X) begin
                    next_ovf = 1'b1;
                    // An oversized step could wrap past MAX_VAL; clamp keeps out in range.
                    if (sat_mode || (sum > MAX_X + MAX_P1))
                        next_out = MAX_VAL;
                    else
                        next_out = WIDTH'(sum - MAX_P1);
                end else begin
                    next_out = WIDTH'(sum);
                end
            end else begin
                if (cur_x < step_x) begin
                    next_unf = 1'b1;
                    if (sat_mode || (step_x > cur_x + MAX_P1))
                        next_out = '0;
                    else
                        next_out = WIDTH'(cur_x + MAX_P1 - step_x);
                end else begin
                    next_out = WIDTH'(cur_x - step_x);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            out <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            out <= next_out;
            ovf <= next_ovf;
            unf <= next_unf;
        end
    end

    assign tc = updown ? (out == MAX_VAL) : (out == '0);

`ifdef DVSD_CNT_STICKY_FLAG_EN
    logic sticky_q;

    // A crossing on the same edge as ovf_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset)
            sticky_q <= 1'b0;
        else if (next_ovf || next_unf)
            sticky_q <= 1'b1;
        else if (ovf_clr)
            sticky_q <= 1'b0;
    end

    assign ovf_sticky = sticky_q;
`else
    logic unused_ovf_clr;

    assign unused_ovf_clr = ovf_clr;
    assign ovf_sticky     = 1'b0;
`endif

endmodule

// File: tb/tb_dvsd_param_updown_counter.sv
// Self-checking bench for dvsd_param_updown_counter (WIDTH=4, MAX_VAL=9, STEP_W=2).
// Directed boundary sequences followed by randomized traffic against an integer reference model.
module tb_dvsd_param_updown_counter;

    localparam int WIDTH  = 4;
    localparam int MAXV   = 9;
    localparam int STEP_W = 2;

    logic              clk = 1'b0;
    logic              reset, en, updown, sat_mode, load, ovf_clr;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  load_val;
    logic [WIDTH-1:0]  out;
    logic              tc, ovf, unf, ovf_sticky;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_out    = 0;
    int m_ovf    = 0;
    int m_unf    = 0;
    int m_sticky = 0;

    dvsd_param_updown_counter #(
        .WIDTH  (WIDTH),
        .MAX_VAL(4'd9),
        .STEP_W (STEP_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .updown    (updown),
        .sat_mode  (sat_mode),
        .step      (step),
        .load      (load),
        .load_val  (load_val),
        .ovf_clr   (ovf_clr),
        .out       (out),
        .tc        (tc),
        .ovf       (ovf),
        .unf       (unf),
        .ovf_sticky(ovf_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    function automatic bit sticky_enabled();
`ifdef DVSD_CNT_STICKY_FLAG_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Behavioural rule set, evaluated once per rising edge with the inputs held across it.
    task automatic model_edge();
        int v;
        if (reset) begin
            m_out = 0; m_ovf = 0; m_unf = 0; m_sticky = 0;
            return;
        end
        m_ovf = 0;
        m_unf = 0;
        if (load) begin
            m_out = (int'(load_val) < MAXV) ? int'(load_val) : MAXV;
        end else if (en) begin
            if (updown) begin
                v = m_out + int'(step);
                if (v > MAXV) begin
                    m_ovf = 1;
                    m_out = sat_mode ? MAXV : v - (MAXV + 1);
                end else m_out = v;
            end else begin
                v = m_out - int'(step);
                if (v < 0) begin
                    m_unf = 1;
                    m_out = sat_mode ? 0 : v + (MAXV + 1);
                end else m_out = v;
            end
        end
        if (sticky_enabled()) begin
            if (m_ovf || m_unf) m_sticky = 1;
            else if (ovf_clr)   m_sticky = 0;
        end else begin
            m_sticky = 0;
        end
    endtask

    // Apply one cycle of inputs, let one edge pass, compare shortly after it.
    task automatic drive(input logic r, input logic l, input logic e, input logic ud,
                         input logic sm, input int st, input int lv, input logic oc);
        int exp_tc;
        reset = r; load = l; en = e; updown = ud; sat_mode = sm;
        step = STEP_W'(st); load_val = WIDTH'(lv); ovf_clr = oc;
        @(posedge clk);
        model_edge();
        #1;
        exp_tc = ud ? int'(m_out == MAXV) : int'(m_out == 0);
        check("out", int'(out), m_out);
        check("tc", int'(tc), exp_tc);
        check("ovf", int'(ovf), m_ovf);
        check("unf", int'(unf), m_unf);
        check("ovf_sticky", int'(ovf_sticky), m_sticky);
        check("ovf_unf_excl", int'(ovf & unf), 0);
    endtask

    initial begin : stim
        int up_seq[10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0};
        int dn_seq[4]  = '{8, 5, 2, 9};
        int dn_unf[4]  = '{1, 0, 0, 1};
        int sticky_exp;

        reset = 1'b1; en = 1'b0; updown = 1'b1; sat_mode = 1'b0;
        step = '0; load = 1'b0; load_val = '0; ovf_clr = 1'b0;

        // Reset, with load and en also asserted
        drive(1, 1, 1, 1, 0, 1, 5, 0);
        drive(1, 0, 0, 1, 0, 0, 0, 0);
        check("reset_out", int'(out), 0);

        // Up, wrap, step 1: 1..9,0 with ovf only on 9->0
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 1, 1, 0, 1, 0, 0);
            check("up_wrap_seq", int'(out), up_seq[i]);
            check("up_wrap_ovf", int'(ovf), int'(i == 9));
            if (i == 8) check("tc_at_max", int'(tc), 1);
        end

        // Down, wrap, step 3 from 1: 8,5,2,9 with unf on 1->8 and 2->9
        drive(0, 1, 0, 0, 0, 3, 1, 0);
        check("load_1", int'(out), 1);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 0, 0, 3, 0, 0);
            check("dn_wrap_seq", int'(out), dn_seq[i]);
            check("dn_wrap_unf", int'(unf), dn_unf[i]);
        end

        // Up, saturate, step 2 from 8: clamps at 9, ovf every clamped edge
        drive(0, 1, 0, 1, 1, 2, 8, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 1, 1, 2, 0, 0);
            check("sat_up_out", int'(out), 9);
            check("sat_up_ovf", int'(ovf), 1);
            check("sat_up_tc", int'(tc), 1);
        end

        // Down, saturate: 1 - 3 clamps to 0
        drive(0, 1, 0, 0, 1, 3, 1, 0);
        drive(0, 0, 1, 0, 1, 3, 0, 0);
        check("sat_dn_out", int'(out), 0);
        check("sat_dn_unf", int'(unf), 1);

        // Load above MAX_VAL clamps and beats en; reset beats load
        drive(0, 1, 1, 1, 0, 3, 15, 0);
        check("load_clamp", int'(out), 9);
        check("load_no_ovf", int'(ovf), 0);
        drive(1, 1, 1, 1, 0, 1, 7, 0);
        check("reset_over_load", int'(out), 0);

        // Reset mid-count at 6, then resume from 0; en=0 holds for 5 cycles
        drive(0, 1, 0, 1, 0, 1, 5, 0);
        drive(0, 0, 1, 1, 0, 1, 0, 0);
        check("pre_reset_6", int'(out), 6);
        drive(1, 0, 1, 1, 0, 1, 0, 0);
        check("mid_reset", int'(out), 0);
        drive(0, 0, 1, 1, 0, 1, 0, 0);
        check("resume", int'(out), 1);
        drive(0, 1, 0, 1, 0, 0, 3, 0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, i[0], i[1], 3, 0, 0);
            check("hold", int'(out), 3);
        end

        // Sticky flag: set by wrap, persists, cleared, then set wins over clear
        sticky_exp = sticky_enabled() ? 1 : 0;
        drive(1, 0, 0, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 1, 0, 1, 9, 0);
        drive(0, 0, 1, 1, 0, 1, 0, 0);
        check("sticky_set", int'(ovf_sticky), sticky_exp);
        drive(0, 0, 0, 1, 0, 1, 0, 0);
        drive(0, 0, 1, 1, 0, 1, 0, 0);
        check("sticky_hold", int'(ovf_sticky), sticky_exp);
        drive(0, 0, 0, 1, 0, 1, 0, 1);
        check("sticky_clr", int'(ovf_sticky), 0);
        drive(0, 1, 0, 1, 0, 1, 9, 0);
        drive(0, 0, 1, 1, 0, 1, 0, 1);
        check("sticky_set_wins", int'(ovf_sticky), sticky_exp);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(63) == 0),
                  ($urandom_range(7) == 0),
                  ($urandom_range(3) != 0),
                  1'($urandom),
                  1'($urandom),
                  int'($urandom_range(3)),
                  int'($urandom_range(15)),
                  ($urandom_range(5) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
